// File: rtl/imem_responder.sv
// rtl/imem_responder.sv - instruction memory responder with wait states, flush, and program-load port
// Single-outstanding fetch engine: IDLE accepts, WAIT counts wait states, RESP holds the answer.
module imem_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_3000,
    parameter int          DEPTH_WORDS = 4096,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           req_valid,
    input  logic [31:0]                    req_addr,
    output logic                           req_ready,
    input  logic                           flush,
    output logic                           resp_valid,
    input  logic                           resp_ready,
    output logic [31:0]                    resp_instr,
    output logic [31:0]                    resp_addr,
    output logic [1:0]                     resp_err,
    input  logic                           ld_en,
    input  logic [$clog2(DEPTH_WORDS)-1:0] ld_idx,
    input  logic [31:0]                    ld_data
);

    localparam int          IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [32:0] SPAN  = 33'(DEPTH_WORDS) * 33'd4;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state, state_n;
    logic [3:0]  cnt, cnt_n;
    logic [31:0] mem [DEPTH_WORDS];

    logic        accept;
    logic [31:0] req_off;
    logic [1:0]  req_err;
    logic [31:0] rd_off;
    logic [IDX_W-1:0] rd_idx;
    logic        enter_resp;

    assign req_ready  = (state == IDLE) && !flush && !reset;
    assign accept     = req_valid && req_ready;
    assign resp_valid = (state == RESP);

    // Misalignment wins over range; range check is done in 33 bits so the span cannot overflow.
    assign req_off = req_addr - BASE_ADDR;
    always_comb begin
        req_err = 2'b00;
        if (req_addr[1:0] != 2'b00) begin
            req_err = 2'b01;
        end else if ({1'b0, req_off} >= SPAN) begin
            req_err = 2'b10;
        end
    end

    // From IDLE the address is still on req_addr; from WAIT it has already been latched.
    assign rd_off = ((state == IDLE) ? req_addr : resp_addr) - BASE_ADDR;
    assign rd_idx = IDX_W'(rd_off >> 2);

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (req_err != 2'b00 || WAIT_CYCLES == 0) begin
                        state_n = RESP;
                    end else begin
                        state_n = WAIT;
                        cnt_n   = 4'(WAIT_CYCLES - 1);
                    end
                end
            end
            WAIT: begin
                if (flush) begin
                    state_n = IDLE;
                    cnt_n   = 4'd0;
                end else if (cnt == 4'd0) begin
                    state_n = RESP;
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            RESP: begin
                if (flush || resp_ready) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = 4'd0;
            end
        endcase
    end

    assign enter_resp = (state_n == RESP) && (state != RESP);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            resp_instr <= 32'd0;
            resp_addr  <= 32'd0;
            resp_err   <= 2'b00;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (accept) begin
                resp_addr <= req_addr;
                resp_err  <= req_err;
            end
            // Nonblocking read of mem gives read-before-write against a same-edge load.
            if (enter_resp) begin
                if (state == IDLE && req_err != 2'b00) begin
                    resp_instr <= 32'd0;
                end else begin
                    resp_instr <= mem[rd_idx];
                end
            end
        end
    end

    // Program memory is deliberately outside the reset domain.
    always_ff @(posedge clk) begin
        if (ld_en) begin
            mem[ld_idx] <= ld_data;
        end
    end

endmodule

// File: tb/tb_imem_responder.sv
// tb/tb_imem_responder.sv - scoreboard bench for imem_responder
module tb_imem_responder;

    localparam int WAIT_CYCLES = 2;
    localparam logic [31:0] W0     = 32'h3C01_0001;
    localparam logic [31:0] W1     = 32'h2402_0005;
    localparam logic [31:0] W1_NEW = 32'h2403_0007;
    localparam logic [31:0] WLAST  = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_ready;
    logic        flush;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_instr;
    logic [31:0] resp_addr;
    logic [1:0]  resp_err;
    logic        ld_en;
    logic [11:0] ld_idx;
    logic [31:0] ld_data;

    imem_responder #(
        .BASE_ADDR   (32'h0000_3000),
        .DEPTH_WORDS (4096),
        .WAIT_CYCLES (WAIT_CYCLES)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .req_ready  (req_ready),
        .flush      (flush),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_instr (resp_instr),
        .resp_addr  (resp_addr),
        .resp_err   (resp_err),
        .ld_en      (ld_en),
        .ld_idx     (ld_idx),
        .ld_data    (ld_data)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] addr;
        logic [1:0]  err;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   vld_cnt = 0;

    function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endfunction

    // Monitor: pops the scoreboard on every response handshake.
    always @(negedge clk) begin
        if (!reset && resp_valid) begin
            vld_cnt++;
            if (resp_ready) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_resp addr=%h instr=%h err=%0d", resp_addr, resp_instr, resp_err);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("resp_instr", resp_instr, e.instr);
                    chk("resp_addr", resp_addr, e.addr);
                    chk("resp_err", {30'd0, resp_err}, {30'd0, e.err});
                end
            end
        end
    end

    task automatic load(input logic [11:0] idx, input logic [31:0] data);
        @(posedge clk); #1;
        ld_en = 1'b1; ld_idx = idx; ld_data = data;
        @(posedge clk); #1;
        ld_en = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] addr, input logic [31:0] instr, input logic [1:0] err, input int bp);
        int n;
        q.push_back({instr, addr, err});
        @(posedge clk); #1;
        resp_ready = (bp == 0);
        req_valid = 1'b1; req_addr = addr;
        @(negedge clk);
        chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            if (resp_valid) break;
            n++;
        end
        chk("latency", n, (err != 2'b00) ? 32'd0 : 32'(WAIT_CYCLES));
        for (int i = 0; i < bp; i++) begin
            if (i > 0) @(negedge clk);
            chk("bp_valid", {31'd0, resp_valid}, 32'd1);
            chk("bp_instr", resp_instr, instr);
            chk("bp_addr", resp_addr, addr);
        end
        if (bp > 0) begin
            @(posedge clk); #1;
            resp_ready = 1'b1;
            @(negedge clk);
        end
        @(posedge clk);
        @(negedge clk);
        chk("idle_after_hs_valid", {31'd0, resp_valid}, 32'd0);
        chk("idle_after_hs_ready", {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        int v0;
        reset = 1'b1; req_valid = 1'b0; req_addr = 32'd0; flush = 1'b0;
        resp_ready = 1'b1; ld_en = 1'b0; ld_idx = '0; ld_data = '0;
        #12;
        chk("rst_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_instr", resp_instr, 32'd0);
        chk("rst_addr", resp_addr, 32'd0);
        chk("rst_err", {30'd0, resp_err}, 32'd0);
        reset = 1'b0;

        load(12'd0, W0);
        load(12'd1, W1);
        load(12'd4095, WLAST);

        fetch(32'h0000_3000, W0, 2'b00, 0);
        fetch(32'h0000_3004, W1, 2'b00, 5);
        fetch(32'h0000_3002, 32'd0, 2'b01, 0);
        fetch(32'h0000_2FFC, 32'd0, 2'b10, 0);
        fetch(32'h0000_7000, 32'd0, 2'b10, 0);
        fetch(32'h0000_6FFC, WLAST, 2'b00, 0);

        // Flush in the first WAIT cycle drops the fetch.
        v0 = vld_cnt;
        @(posedge clk); #1;
        req_valid = 1'b1; req_addr = 32'h0000_3000;
        @(posedge clk); #1;
        req_valid = 1'b0; flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        repeat (6) @(negedge clk);
        chk("flush_wait_no_resp", vld_cnt - v0, 32'd0);
        fetch(32'h0000_3004, W1, 2'b00, 0);

        // Flush in IDLE blocks acceptance.
        v0 = vld_cnt;
        @(posedge clk); #1;
        req_valid = 1'b1; req_addr = 32'h0000_3000; flush = 1'b1;
        @(negedge clk);
        chk("flush_idle_ready", {31'd0, req_ready}, 32'd0);
        @(posedge clk); #1;
        req_valid = 1'b0; flush = 1'b0;
        repeat (5) @(negedge clk);
        chk("flush_idle_no_resp", vld_cnt - v0, 32'd0);

        // Load to index 1 on the RESP-entry edge: old word first, new word on refetch.
        q.push_back({W1, 32'h0000_3004, 2'b00});
        @(posedge clk); #1;
        req_valid = 1'b1; req_addr = 32'h0000_3004;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        ld_en = 1'b1; ld_idx = 12'd1; ld_data = W1_NEW;
        @(posedge clk); #1;
        ld_en = 1'b0;
        @(negedge clk);
        chk("collide_valid", {31'd0, resp_valid}, 32'd1);
        @(posedge clk);
        fetch(32'h0000_3004, W1_NEW, 2'b00, 0);

        // Asynchronous reset mid-WAIT.
        v0 = vld_cnt;
        @(posedge clk); #1;
        req_valid = 1'b1; req_addr = 32'h0000_3000;
        @(posedge clk); #1;
        req_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("arst_valid", {31'd0, resp_valid}, 32'd0);
        chk("arst_ready", {31'd0, req_ready}, 32'd0);
        chk("arst_instr", resp_instr, 32'd0);
        chk("arst_addr", resp_addr, 32'd0);
        chk("arst_err", {30'd0, resp_err}, 32'd0);
        #2 reset = 1'b0;
        repeat (6) @(negedge clk);
        chk("arst_no_resp", vld_cnt - v0, 32'd0);
        fetch(32'h0000_3000, W0, 2'b00, 0);
        fetch(32'h0000_3004, W1_NEW, 2'b00, 0);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule

// File: doc/imem_responder.md
IMEM_RESPONDER -- requirements
Module: imem_responder

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- BASE_ADDR, 32'h00003000, byte address of word 0.
- DEPTH_WORDS, 4096, number of 32-bit words held (power of two).
- WAIT_CYCLES, 2, extra wait states before a normal response (0..15).

REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  fetch request present.
- req_addr  in  32  fetch byte address (PC).
- req_ready  out  1  request accepted this cycle when high with req_valid.
- flush  in  1  discard any in-flight fetch (jump taken).
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer takes response.
- resp_instr  out  32  fetched word; 0 on error.
- resp_addr  out  32  req_addr of the request being answered.
- resp_err  out  2  00 ok, 01 misaligned, 10 out of range.
- ld_en  in  1  program-load write strobe.
- ld_idx  in  log2(DEPTH_WORDS)  program-load word index.
- ld_data  in  32  program-load word.

Function
REQ-003 The FSM SHALL have states IDLE, WAIT and RESP.
REQ-004 req_ready SHALL equal (state==IDLE) && !flush && !reset.
REQ-005 Accept (req_valid && req_ready) SHALL latch req_addr into resp_addr and classify it. Misaligned = req_addr[1:0]!=0 and takes priority. Out of range = (req_addr - BASE_ADDR), 32-bit unsigned wrap, >= DEPTH_WORDS*4.
REQ-006 On accept with an error, the FSM SHALL go to RESP next cycle with resp_instr=0 and the error code. No memory read occurs.
REQ-007 On an ok accept with WAIT_CYCLES==0, the FSM SHALL go to RESP next cycle. Otherwise it SHALL go to WAIT, with the wait counter loaded to WAIT_CYCLES-1.
REQ-008 In WAIT, the counter SHALL decrement each cycle. At 0 the FSM SHALL go to RESP. An ok response therefore appears exactly WAIT_CYCLES+1 cycles after accept.
REQ-009 The memory word at index (resp_addr - BASE_ADDR)>>2 SHALL be sampled into resp_instr on the edge that enters RESP.
REQ-010 resp_valid SHALL be 1 exactly when state==RESP. resp_instr, resp_addr and resp_err SHALL be held stable while resp_valid && !resp_ready.
REQ-011 In RESP with resp_ready=1, the FSM SHALL return to IDLE. There SHALL be no back-to-back accept in that cycle, so at least one IDLE cycle occurs between responses.
REQ-012 flush=1 in WAIT or RESP SHALL force IDLE next cycle, drop the response, and clear the counter. flush in RESP with resp_ready=1 still drops it (no handshake counted). flush in IDLE blocks acceptance (REQ-004).
REQ-013 ld_en=1 SHALL write ld_data to ld_idx at the clock edge, in any state. If this coincides with the read sample of REQ-009 at the same index, resp_instr SHALL get the old word (read-before-write).
REQ-014 Output registers (resp_instr, resp_addr, resp_err) SHALL be unchanged in IDLE and WAIT.

Reset
REQ-015 reset=1 SHALL immediately, without a clock, force state=IDLE, counter=0, resp_valid=0, resp_instr=0, resp_addr=0, resp_err=00 and req_ready=0.
REQ-016 Reset asserted mid-WAIT or mid-RESP SHALL abort the fetch. No response appears after release.
REQ-017 Memory contents SHALL NOT be affected by reset.
REQ-018 The first accept SHALL be possible on the first rising edge after reset deasserts.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- Normal fetch (WAIT_CYCLES=2). Stimulus: ld word 0=32'h3C010001; req 32'h00003000 accepted at edge N. Response: resp_valid rises after edge N+3; resp_instr=32'h3C010001, resp_err=00.
- Backpressure. Stimulus: resp_ready=0 for 5 cycles, then 1. Response: resp_valid and data stable for all 5 cycles; IDLE and req_ready=1 the cycle after the handshake.
- Misaligned. Stimulus: req 32'h00003002. Response: after 1 cycle, resp_err=01, resp_instr=0. Stimulus: req 32'h00002FFC. Response: resp_err=10. Stimulus: req 32'h00007000 (DEPTH 4096). Response: resp_err=10.
- Flush. Stimulus: flush in the first WAIT cycle. Response: no resp_valid; the next request 32'h00003004 returns word 1 with normal latency. Stimulus: flush with req_valid in IDLE. Response: req_ready=0, request not taken.
- Load collision. Stimulus: ld_en to index 1 on the RESP-entry edge of a fetch of 32'h00003004. Response: old word returned; a refetch returns the new word.
- Async reset mid-WAIT. Stimulus: reset pulse between clock edges. Response: outputs zero at once, resp_valid never asserts; memory still holds loaded words afterwards.
